nonce_search_sequencer: RTL

//  Sequences one shared multi-cycle SHA-256 compression core through the Bitcoin double hash.
//  Per job: one midstate pass over header block 1 (computed once and cached).
//  Per nonce: block-2 pass, then final pass over the 256-bit digest.

---
 rtl/nonce_search_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nonce_search_sequencer.sv
// ============================================================================
//  Module   : nonce_search_sequencer
//  Brief    : Drives one shared SHA-256 compression core through the Bitcoin
//             double hash: cached midstate, then block-2 and final pass per nonce.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nonce_search_sequencer #(
   parameter int          ZERO_BITS  = 19,
   parameter logic [31:0] NONCE_LAST = 32'hFFFF_FFFF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [639:0] job_header,
   input  logic         abort,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic [255:0] core_hin,
   input  logic         core_done,
   input  logic [255:0] core_hout,
   output logic         found_valid,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   input  logic         found_ack,
   output logic         busy,
   output logic         exhausted
);

   localparam logic [255:0] C_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_MID_REQ  = 4'd1;
   localparam logic [3:0] S_MID_WAIT = 4'd2;
   localparam logic [3:0] S_B2_REQ   = 4'd3;
   localparam logic [3:0] S_B2_WAIT  = 4'd4;
   localparam logic [3:0] S_FIN_REQ  = 4'd5;
   localparam logic [3:0] S_FIN_WAIT = 4'd6;
   localparam logic [3:0] S_CHECK    = 4'd7;
   localparam logic [3:0] S_FOUND    = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;
   localparam logic [3:0] S_DRAIN    = 4'd10;

   logic [3:0]   state_q, state_d;
   logic [639:32] header_q, header_d;
   logic [31:0]  nonce_q, nonce_d;
   logic [255:0] midstate_q, midstate_d;
   logic [255:0] digest_q, digest_d;
   logic         found_valid_q, found_valid_d;
   logic [31:0]  found_nonce_q, found_nonce_d;
   logic [255:0] found_hash_q, found_hash_d;
   logic         exhausted_q, exhausted_d;

   logic w_hit, w_last, w_idle;

   assign w_hit  = (digest_q[255 -: ZERO_BITS] == '0);
   assign w_last = (nonce_q == NONCE_LAST);
   assign w_idle = (state_q == S_IDLE) || (state_q == S_DONE);

   always_comb begin
      state_d       = state_q;
      header_d      = header_q;
      nonce_d       = nonce_q;
      midstate_d    = midstate_q;
      digest_d      = digest_q;
      found_valid_d = found_valid_q;
      found_nonce_d = found_nonce_q;
      found_hash_d  = found_hash_q;
      exhausted_d   = exhausted_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (job_valid) begin
               header_d    = job_header[639:32];
               nonce_d     = job_header[31:0];
               exhausted_d = 1'b0;
               state_d     = S_MID_REQ;
            end
         end
         S_MID_REQ:  state_d = abort ? S_IDLE : S_MID_WAIT;
         S_B2_REQ:   state_d = abort ? S_IDLE : S_B2_WAIT;
         S_FIN_REQ:  state_d = abort ? S_IDLE : S_FIN_WAIT;
         S_MID_WAIT: begin
            if (abort) begin
               state_d = core_done ? S_IDLE : S_DRAIN;
            end else if (core_done) begin
               midstate_d = core_hout;
               state_d    = S_B2_REQ;
            end
         end
         S_B2_WAIT: begin
            if (abort) begin
               state_d = core_done ? S_IDLE : S_DRAIN;
            end else if (core_done) begin
               digest_d = core_hout;
               state_d  = S_FIN_REQ;
            end
         end
         S_FIN_WAIT: begin
            if (abort) begin
               state_d = core_done ? S_IDLE : S_DRAIN;
            end else if (core_done) begin
               digest_d = core_hout;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (w_hit) begin
               found_valid_d = 1'b1;
               found_nonce_d = nonce_q;
               found_hash_d  = digest_q;
               state_d       = S_FOUND;
            end else if (w_last) begin
               exhausted_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               nonce_d = nonce_q + 32'd1;
               state_d = S_B2_REQ;
            end
         end
         S_FOUND: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (found_ack) begin
               found_valid_d = 1'b0;
               if (w_last) begin
                  exhausted_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  nonce_d = nonce_q + 32'd1;
                  state_d = S_B2_REQ;
               end
            end
         end
         S_DRAIN:  if (core_done) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort && !w_idle) found_valid_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         header_q      <= '0;
         nonce_q       <= '0;
         midstate_q    <= '0;
         digest_q      <= '0;
         found_valid_q <= 1'b0;
         found_nonce_q <= '0;
         found_hash_q  <= '0;
         exhausted_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         header_q      <= header_d;
         nonce_q       <= nonce_d;
         midstate_q    <= midstate_d;
         digest_q      <= digest_d;
         found_valid_q <= found_valid_d;
         found_nonce_q <= found_nonce_d;
         found_hash_q  <= found_hash_d;
         exhausted_q   <= exhausted_d;
      end
   end

   // An aborted request never reaches the core, so no stale core_done can follow.
   assign core_start = ((state_q == S_MID_REQ) || (state_q == S_B2_REQ) ||
                        (state_q == S_FIN_REQ)) && !abort;

   always_comb begin
      core_block = '0;
      core_hin   = '0;
      case (state_q)
         S_MID_REQ, S_MID_WAIT: begin
            core_block = header_q[639:128];
            core_hin   = C_IV;
         end
         S_B2_REQ, S_B2_WAIT: begin
            core_block = {header_q[127:32], nonce_q, 1'b1, 319'b0, 64'd640};
            core_hin   = midstate_q;
         end
         S_FIN_REQ, S_FIN_WAIT: begin
            core_block = {digest_q, 1'b1, 191'b0, 64'd256};
            core_hin   = C_IV;
         end
         default: ;
      endcase
   end

   assign job_ready   = w_idle;
   assign busy        = !w_idle;
   assign found_valid = found_valid_q;
   assign found_nonce = found_nonce_q;
   assign found_hash  = found_hash_q;
   assign exhausted   = exhausted_q;

endmodule

`default_nettype wire
